// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: unit selectors, FSM states, opcodes.
package alu_pkg;

    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] FUN_ADD    = 4'b0000;
    localparam logic [3:0] FUN_SUB    = 4'b0001;
    localparam logic [3:0] FUN_MUL    = 4'b0010;
    localparam logic [3:0] FUN_AND    = 4'b0100;
    localparam logic [3:0] FUN_OR     = 4'b0101;
    localparam logic [3:0] FUN_CMP_EQ = 4'b1000;
    localparam logic [3:0] FUN_SHR    = 4'b1100;
    localparam logic [3:0] FUN_SHL    = 4'b1101;

endpackage

// File: rtl/alu_result_mux.sv
// Selects flag, result and carry of one ALU unit and formats the result to 2*width bits.
// Latency: combinational. Backpressure: none.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int width = 16
) (
    input  logic [1:0]         i_sel,
    input  logic [2*width-1:0] i_arith_out,
    input  logic               i_carry_out,
    input  logic [width-1:0]   i_logic_out,
    input  logic [width-1:0]   i_cmp_out,
    input  logic [width:0]     i_shift_out,
    input  logic               i_arith_flag,
    input  logic               i_logic_flag,
    input  logic               i_cmp_flag,
    input  logic               i_shift_flag,
    output logic               o_flag,
    output logic [2*width-1:0] o_data,
    output logic               o_carry
);

    always_comb begin
        o_flag  = 1'b0;
        o_data  = '0;
        o_carry = 1'b0;
        case (i_sel)
            ARITH: begin
                o_flag  = i_arith_flag;
                o_data  = i_arith_out;
                o_carry = i_carry_out;
            end
            LOGIC: begin
                o_flag = i_logic_flag;
                o_data = {{width{1'b0}}, i_logic_out};
            end
            CMP: begin
                o_flag = i_cmp_flag;
                o_data = {{width{1'b0}}, i_cmp_out};
            end
            default: begin
                o_flag = i_shift_flag;
                o_data = {{(width-1){1'b0}}, i_shift_out};
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues one ALU command at a time to ALU_TOP and returns the selected unit's result.
// Latency: response valid ALU_LAT+1 cycles after accept, or ALU_LAT+TIMEOUT+1 on timeout.
// Backpressure: response held stable until rsp_ready; no new command accepted meanwhile.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int width   = 16,
    parameter int ALU_LAT = 1,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [width-1:0]   cmd_a,
    input  logic [width-1:0]   cmd_b,
    input  logic [3:0]         cmd_fun,
    output logic [width-1:0]   ALU_A,
    output logic [width-1:0]   ALU_B,
    output logic [3:0]         ALU_FUN,
    input  logic [2*width-1:0] Arith_OUT,
    input  logic [width-1:0]   Logic_OUT,
    input  logic [width-1:0]   CMP_OUT,
    input  logic [width:0]     SHIFT_OUT,
    input  logic               Carry_OUT,
    input  logic               Arith_Flag,
    input  logic               Logic_Flag,
    input  logic               CMP_Flag,
    input  logic               SHIFT_Flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*width-1:0] rsp_data,
    output logic               rsp_carry,
    output logic               rsp_err,
    output logic [CNT_W-1:0]   op_count
);

    localparam int WC_W = $clog2(ALU_LAT + TIMEOUT + 1);
    localparam logic [WC_W-1:0] LAT_C = WC_W'(ALU_LAT);
    localparam logic [WC_W-1:0] LIM_C = WC_W'(ALU_LAT + TIMEOUT);

    state_t             r_state;
    state_t             w_next_state;
    logic [WC_W-1:0]    r_wait_cnt;
    logic [width-1:0]   r_alu_a;
    logic [width-1:0]   r_alu_b;
    logic [3:0]         r_alu_fun;
    logic [2*width-1:0] r_rsp_data;
    logic               r_rsp_carry;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_flag;
    logic [2*width-1:0] w_data;
    logic               w_carry;
    logic               w_accept;
    logic               w_capture;
    logic               w_timeout;
    logic               w_rsp_hs;

    alu_result_mux #(.width(width)) u_mux (
        .i_sel        (r_alu_fun[3:2]),
        .i_arith_out  (Arith_OUT),
        .i_carry_out  (Carry_OUT),
        .i_logic_out  (Logic_OUT),
        .i_cmp_out    (CMP_OUT),
        .i_shift_out  (SHIFT_OUT),
        .i_arith_flag (Arith_Flag),
        .i_logic_flag (Logic_Flag),
        .i_cmp_flag   (CMP_Flag),
        .i_shift_flag (SHIFT_Flag),
        .o_flag       (w_flag),
        .o_data       (w_data),
        .o_carry      (w_carry)
    );

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    // Flags inside the mask window still belong to the previous operation.
    assign w_capture = (r_state == WAIT) && w_flag && (r_wait_cnt >= LAT_C);
    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == LIM_C);
    assign w_rsp_hs  = (r_state == RESP) && rsp_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = WAIT;
            WAIT:    if (w_capture || w_timeout) w_next_state = RESP;
            RESP:    if (w_rsp_hs) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wait_cnt  <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_rsp_data  <= '0;
            r_rsp_carry <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            if (w_accept) begin
                r_alu_a    <= cmd_a;
                r_alu_b    <= cmd_b;
                r_alu_fun  <= cmd_fun;
                r_wait_cnt <= '0;
            end
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + WC_W'(1);
            end
            // Capture has priority over a timeout landing on the same edge.
            if (w_capture) begin
                r_rsp_data  <= w_data;
                r_rsp_carry <= w_carry;
                r_rsp_err   <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_data  <= '0;
                r_rsp_carry <= 1'b0;
                r_rsp_err   <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign cmd_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign rsp_data  = r_rsp_data;
    assign rsp_carry = r_rsp_carry;
    assign rsp_err   = r_rsp_err;
    assign op_count  = r_op_count;

endmodule
